// File: rtl/reg_dump_pkg.sv
// Shared types and sizing helpers for the register dump scanner.
// The optional checksum trailer is enabled with REG_DUMP_CHECKSUM_EN.
package reg_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    CSUM  = 2'd3
  } dumpState_t;

  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_ADDR_W   = 5;
  localparam int DEFAULT_DATA_W   = 32;

  function automatic int bytesPerReg(input int dataW);
    return dataW / 8;
  endfunction

  // One address byte followed by the data bytes of a register.
  function automatic int recordLen(input int dataW);
    return 1 + bytesPerReg(dataW);
  endfunction

  localparam int DEFAULT_RECORD_LEN = recordLen(DEFAULT_DATA_W);

endpackage

// File: rtl/reg_dump_ser.sv
// Record serializer: latches one register word and presents its address byte
// followed by the data bytes, MSB first, advancing on each accepted byte.
module reg_dump_ser
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              sendEn,
  input  logic              outReady,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        byteData,
  output logic              fire,
  output logic              lastByte
);

  localparam int BPR   = bytesPerReg(DATA_W);
  localparam int IDX_W = $clog2(BPR + 1);

  logic [DATA_W-1:0] dataReg;
  logic [IDX_W-1:0]  byteIdx;

  assign fire     = sendEn & outReady;
  assign lastByte = (byteIdx == IDX_W'(BPR));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dataReg <= '0;
      byteIdx <= '0;
    end else if (load) begin
      dataReg <= dataIn;
      byteIdx <= '0;
    end else if (fire) begin
      byteIdx <= byteIdx + 1'b1;
    end
  end

  // Index 0 is the zero-extended address; index k+1 is data byte k from the top.
  always_comb begin
    byteData = '0;
    if (byteIdx == '0) begin
      byteData = 8'(addr);
    end else begin
      for (int k = 0; k < BPR; k++) begin
        if (byteIdx == IDX_W'(k + 1)) byteData = dataReg[DATA_W-1-8*k -: 8];
      end
    end
  end

endmodule

// File: rtl/reg_dump_scanner.sv
// Sweeps the register file debug port and streams each register as a byte
// record. Define REG_DUMP_CHECKSUM_EN to append a modulo-256 checksum byte.
module reg_dump_scanner
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DATA_W   = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  dumpState_t        state, nextState;
  logic [ADDR_W-1:0] addr;
  logic              doneNext;
  logic              loadData;
  logic              sendEn;
  logic              serFire;
  logic              serLastByte;
  logic [7:0]        serByte;
  logic              recordDone;
  logic              startAccepted;

  assign recordDone    = serFire & serLastByte;
  assign startAccepted = (state == IDLE) & start;

  reg_dump_ser #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ser (
    .clock    (clock),
    .reset    (reset),
    .load     (loadData),
    .sendEn   (sendEn),
    .outReady (out_ready),
    .dataIn   (debug_data),
    .addr     (addr),
    .byteData (serByte),
    .fire     (serFire),
    .lastByte (serLastByte)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      addr  <= '0;
    end else begin
      state <= nextState;
      done  <= doneNext;
      if (startAccepted) begin
        addr <= '0;
      end else if (recordDone && addr != LAST_ADDR) begin
        addr <= addr + 1'b1;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    nextState = state;
    doneNext  = 1'b0;
    loadData  = 1'b0;
    sendEn    = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = FETCH;
      end
      FETCH: begin
        loadData  = 1'b1;
        nextState = SEND;
      end
      SEND: begin
        sendEn = 1'b1;
        if (recordDone) begin
          if (addr != LAST_ADDR) begin
            nextState = FETCH;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            nextState = CSUM;
`else
            nextState = IDLE;
            doneNext  = 1'b1;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        if (out_ready) begin
          nextState = IDLE;
          doneNext  = 1'b1;
        end
      end
`endif
      default: nextState = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign debug_addr = addr;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csum <= '0;
    end else if (startAccepted) begin
      csum <= '0;
    end else if (serFire) begin
      csum <= csum + serByte;
    end
  end

  assign out_valid = (state == SEND) || (state == CSUM);
  assign out_last  = (state == CSUM);

  always_comb begin
    out_data = '0;
    if (state == SEND) out_data = serByte;
    else if (state == CSUM) out_data = csum;
  end
`else
  assign out_valid = (state == SEND);
  assign out_last  = (state == SEND) && serLastByte && (addr == LAST_ADDR);
  assign out_data  = (state == SEND) ? serByte : 8'h00;
`endif

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Directed bench for reg_dump_scanner: register-file model on the debug port,
// byte capture with handshake-stability checks, expected streams built locally.
module tb_reg_dump_scanner;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int DUMP_CYCLES = 193;
`else
  localparam int DUMP_CYCLES = 192;
`endif

  logic              clock;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] debugAddr;
  logic [DATA_W-1:0] debugData;
  logic              outValid;
  logic              outReady;
  logic [7:0]        outData;
  logic              outLast;

  logic [DATA_W-1:0] regs [NUM_REGS];
  assign debugData = regs[debugAddr];

  reg_dump_scanner #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .debug_addr (debugAddr),
    .debug_data (debugData),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .out_last   (outLast)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] gotBytes [$];
  logic       gotLast  [$];
  logic [7:0] expBytes [$];
  int doneCount, doneCycle, firstValidCycle, stallErrs, busyCycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearRegs();
    for (int r = 0; r < NUM_REGS; r++) regs[r] = '0;
  endtask

  task automatic buildExpected();
    logic [7:0] sum;
    sum = 8'h00;
    expBytes.delete();
    for (int r = 0; r < NUM_REGS; r++) begin
      expBytes.push_back(8'(r));
      for (int k = 0; k < 4; k++) expBytes.push_back(regs[r][31-8*k -: 8]);
    end
    for (int i = 0; i < expBytes.size(); i++) sum = sum + expBytes[i];
`ifdef REG_DUMP_CHECKSUM_EN
    expBytes.push_back(sum);
`endif
  endtask

  // Runs one dump from a start pulse. resetAtByte >= 0 asserts reset while that
  // byte index is presented and returns with reset held high.
  task automatic runDump(input bit randomReady, input bit midStart,
                         input bit writeR5, input int resetAtByte);
    bit         havePrev;
    logic [7:0] prevData;
    logic       prevLast;
    int         edgeCount;
    int         tail;
    gotBytes.delete();
    gotLast.delete();
    doneCount = 0; doneCycle = -1; firstValidCycle = -1;
    stallErrs = 0; busyCycles = 0;
    havePrev = 1'b0; prevData = '0; prevLast = 1'b0;
    edgeCount = 0; tail = 0;
    @(posedge clock); #1;
    start    = 1'b1;
    outReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    while (edgeCount < 3000 && tail < 4) begin
      @(negedge clock);
      if (busy) busyCycles++;
      if (outValid && firstValidCycle < 0) firstValidCycle = edgeCount;
      if (havePrev && (!outValid || outData !== prevData || outLast !== prevLast)) stallErrs++;
      havePrev = outValid && !outReady;
      prevData = outData;
      prevLast = outLast;
      if (resetAtByte >= 0 && outValid && gotBytes.size() == resetAtByte) begin
        reset = 1'b1;
        #1;
        break;
      end
      if (outValid && outReady) begin
        gotBytes.push_back(outData);
        gotLast.push_back(outLast);
      end
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = edgeCount;
      end
      if (writeR5 && debugAddr == 5'd3) regs[5] = 32'h0000_0055;
      if (doneCount > 0) tail++;
      @(posedge clock);
      edgeCount++;
      #1;
      outReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = midStart && (edgeCount == 50);
    end
    start    = 1'b0;
    outReady = 1'b1;
  endtask

  task automatic compareStream(input string tag);
    int mism;
    mism = 0;
    check({tag, "_len"}, gotBytes.size(), expBytes.size());
    for (int i = 0; i < gotBytes.size(); i++) begin
      if (i >= expBytes.size() || gotBytes[i] !== expBytes[i] ||
          gotLast[i] !== (i == expBytes.size() - 1)) mism++;
    end
    check({tag, "_bytes"}, mism, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; outReady = 1'b0;
    clearRegs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", debugAddr, 0);
    check("rst_valid", outValid, 0);
    check("rst_data", outData, 0);
    check("rst_last", outLast, 0);
    reset = 1'b0;

    // Single register populated, no backpressure.
    regs[1] = 32'hDEAD_BEEF;
    runDump(1'b0, 1'b0, 1'b0, -1);
    buildExpected();
    compareStream("plain");
    check("rec0_addr", gotBytes[0], 8'h00);
    check("rec0_data", {gotBytes[1], gotBytes[2], gotBytes[3], gotBytes[4]}, 32'h0);
    check("rec1_addr", gotBytes[5], 8'h01);
    check("rec1_data", {gotBytes[6], gotBytes[7], gotBytes[8], gotBytes[9]}, 32'hDEAD_BEEF);
    check("plain_done_cnt", doneCount, 1);
    check("plain_done_cyc", doneCycle, DUMP_CYCLES);
    check("plain_first_valid", firstValidCycle, 1);
    check("plain_busy_cyc", busyCycles, DUMP_CYCLES);
    check("plain_busy_after", busy, 0);

    // Random backpressure; stream must match and held bytes must stay stable.
    runDump(1'b1, 1'b0, 1'b0, -1);
    compareStream("stall");
    check("stall_stable", stallErrs, 0);
    check("stall_done_cnt", doneCount, 1);

    // Start pulsed mid-dump is ignored.
    runDump(1'b0, 1'b1, 1'b0, -1);
    compareStream("midstart");
    check("midstart_done_cnt", doneCount, 1);
    check("midstart_done_cyc", doneCycle, DUMP_CYCLES);

    // Reset while record 7 byte 2 is on the bus.
    runDump(1'b0, 1'b0, 1'b0, 37);
    check("rst_mid_valid", outValid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", debugAddr, 0);
    check("rst_mid_last", outLast, 0);
    check("rst_mid_bytes", gotBytes.size(), 37);
    @(posedge clock);
    @(negedge clock);
    check("rst_mid_nodone", done, 0);
    check("rst_mid_idle_valid", outValid, 0);
    reset = 1'b0;
    runDump(1'b0, 1'b0, 1'b0, -1);
    compareStream("after_rst");
    check("after_rst_done_cnt", doneCount, 1);

    // Register r5 written while the dump sits on r3.
    clearRegs();
    runDump(1'b0, 1'b0, 1'b1, -1);
    buildExpected();
    compareStream("live_write");
    check("r5_data", {gotBytes[26], gotBytes[27], gotBytes[28], gotBytes[29]}, 32'h0000_0055);

`ifdef REG_DUMP_CHECKSUM_EN
    clearRegs();
    regs[1] = 32'h0102_0304;
    runDump(1'b0, 1'b0, 1'b0, -1);
    check("csum_len", gotBytes.size(), 161);
    check("csum_byte", gotBytes[160], 8'hFA);
    check("csum_last", gotLast[160], 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
